// File: rtl/wb_pkg.sv
// wb_pkg: shared FSM encoding and width constants for the Wishbone RAM slave.
`default_nettype none

package wb_pkg;

   localparam int c_DATA_W     = 32;
   localparam int c_LANE_W     = 8;
   localparam int c_NUM_LANES  = c_DATA_W / c_LANE_W;
   localparam int c_WAIT_CNT_W = 4;

   typedef logic [1:0] wb_state_t;

   localparam logic [1:0] c_ST_IDLE = 2'd0;
   localparam logic [1:0] c_ST_WAIT = 2'd1;
   localparam logic [1:0] c_ST_RESP = 2'd2;

endpackage

`default_nettype wire

// File: rtl/wb_ram_mem.sv
// wb_ram_mem: single-port word RAM with byte-lane write enables and registered read.
`default_nettype none

module wb_ram_mem
   import wb_pkg::*;
#(
   parameter int ADDR_WIDTH = 12
) (
   input  logic                   i_clk,
   input  logic                   i_en,
   input  logic                   i_we,
   input  logic [c_NUM_LANES-1:0] i_sel,
   input  logic [ADDR_WIDTH-1:0]  i_addr,
   input  logic [c_DATA_W-1:0]    i_wdata,
   output logic [c_DATA_W-1:0]    o_rdata
);

   logic [c_DATA_W-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];
   logic [c_DATA_W-1:0] r_rdata;

   // Storage is intentionally not reset so contents survive a bus reset.
   always_ff @(posedge i_clk) begin
      if (i_en) begin
         if (i_we) begin
            for (int n = 0; n < c_NUM_LANES; n++) begin
               if (i_sel[n]) begin
                  r_mem[i_addr][n*c_LANE_W +: c_LANE_W] <= i_wdata[n*c_LANE_W +: c_LANE_W];
               end
            end
         end else begin
            r_rdata <= r_mem[i_addr];
         end
      end
   end

   assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/wb_ram_slave.sv
// wb_ram_slave: pipelined Wishbone RAM slave with optional wait states.
// Define WB_RAM_SLAVE_ERR_EN to error out-of-range requests instead of aliasing.
`default_nettype none

module wb_ram_slave
   import wb_pkg::*;
#(
   parameter int          ADDR_WIDTH  = 12,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          WAIT_CYCLES = 0
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   input  logic        wb_we_i,
   input  logic [31:0] wb_adr_i,
   input  logic [31:0] wb_dat_i,
   input  logic [3:0]  wb_sel_i,
   output logic        wb_stall_o,
   output logic        wb_ack_o,
   output logic        wb_err_o,
   output logic [31:0] wb_dat_o
);

   localparam logic [c_WAIT_CNT_W-1:0] c_WAIT     = c_WAIT_CNT_W'(WAIT_CYCLES);
   localparam logic                    c_HAS_WAIT = (WAIT_CYCLES > 0);

   wb_state_t               r_state;
   wb_state_t               w_state_nxt;
   logic [c_WAIT_CNT_W-1:0] r_cnt;
   logic [c_WAIT_CNT_W-1:0] w_cnt_nxt;
   logic                    r_rd;
   logic [31:0]             w_off;
   logic [ADDR_WIDTH-1:0]   w_idx;
   logic                    w_accept;
   logic                    w_oor;
   logic                    w_mem_en;
   logic                    w_resp;
   logic [c_DATA_W-1:0]     w_rdata;
   logic                    w_unused_bits;

   assign w_off         = wb_adr_i - BASE_ADDR;
   assign w_idx         = w_off[ADDR_WIDTH+1:2];
   assign w_unused_bits = ^{w_off[1:0], w_off[31:ADDR_WIDTH+2]};

   // Without wait states the slave never stalls and sustains one request per cycle.
   assign wb_stall_o = c_HAS_WAIT & (r_state != c_ST_IDLE);
   assign w_accept   = wb_cyc_i & wb_stb_i & ~wb_stall_o;

`ifdef WB_RAM_SLAVE_ERR_EN
   assign w_oor = (w_off >> (ADDR_WIDTH + 2)) != 32'd0;
`else
   assign w_oor = 1'b0;
`endif

   assign w_mem_en = w_accept & ~w_oor;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         c_ST_IDLE, c_ST_RESP: begin
            w_cnt_nxt = '0;
            if (w_accept) begin
               if (c_HAS_WAIT) begin
                  w_state_nxt = c_ST_WAIT;
                  w_cnt_nxt   = c_WAIT_CNT_W'(1);
               end else begin
                  w_state_nxt = c_ST_RESP;
               end
            end else begin
               w_state_nxt = c_ST_IDLE;
            end
         end
         c_ST_WAIT: begin
            if (!wb_cyc_i) begin
               w_state_nxt = c_ST_IDLE;
               w_cnt_nxt   = '0;
            end else if (r_cnt == c_WAIT) begin
               w_state_nxt = c_ST_RESP;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nxt = c_ST_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         r_state <= c_ST_IDLE;
         r_cnt   <= '0;
         r_rd    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_accept) begin
            r_rd <= ~wb_we_i;
         end
      end
   end

   // A response is suppressed if the master abandons the cycle.
   assign w_resp = (r_state == c_ST_RESP) & wb_cyc_i;

`ifdef WB_RAM_SLAVE_ERR_EN
   logic r_err;

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         r_err <= 1'b0;
      end else if (w_accept) begin
         r_err <= w_oor;
      end
   end

   assign wb_ack_o = w_resp & ~r_err;
   assign wb_err_o = w_resp & r_err;
`else
   assign wb_ack_o = w_resp;
   assign wb_err_o = 1'b0;
`endif

   assign wb_dat_o = (wb_ack_o & r_rd) ? w_rdata : 32'h0;

   wb_ram_mem #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_mem (
      .i_clk   (clk_i),
      .i_en    (w_mem_en),
      .i_we    (wb_we_i),
      .i_sel   (wb_sel_i),
      .i_addr  (w_idx),
      .i_wdata (wb_dat_i),
      .o_rdata (w_rdata)
   );

endmodule

`default_nettype wire

// File: tb/tb_wb_ram_slave.sv
// tb_wb_ram_slave: scoreboard bench for a zero-wait and a three-wait-state slave.
`default_nettype none

module tb_wb_ram_slave;

   typedef struct packed {
      logic        err;
      logic        rd;
      logic [31:0] data;
   } sb_t;

   logic        clk;
   logic        rst_n;

   logic        cyc0, stb0, we0, stall0, ack0, err0;
   logic [31:0] adr0, wdat0, rdat0;
   logic [3:0]  sel0;

   logic        cyc3, stb3, we3, stall3, ack3, err3;
   logic [31:0] adr3, wdat3, rdat3;
   logic [3:0]  sel3;

   int          n_checks;
   int          n_fail;
   sb_t         q0[$];
   sb_t         q3[$];
   sb_t         e0;
   sb_t         e3;
   logic [31:0] m0 [0:4095];
   logic [31:0] m3 [0:255];

   wb_ram_slave #(
      .ADDR_WIDTH  (12),
      .BASE_ADDR   (32'h0000_0000),
      .WAIT_CYCLES (0)
   ) u_dut0 (
      .clk_i      (clk),
      .reset_i    (rst_n),
      .wb_cyc_i   (cyc0),
      .wb_stb_i   (stb0),
      .wb_we_i    (we0),
      .wb_adr_i   (adr0),
      .wb_dat_i   (wdat0),
      .wb_sel_i   (sel0),
      .wb_stall_o (stall0),
      .wb_ack_o   (ack0),
      .wb_err_o   (err0),
      .wb_dat_o   (rdat0)
   );

   wb_ram_slave #(
      .ADDR_WIDTH  (8),
      .BASE_ADDR   (32'h0001_0000),
      .WAIT_CYCLES (3)
   ) u_dut3 (
      .clk_i      (clk),
      .reset_i    (rst_n),
      .wb_cyc_i   (cyc3),
      .wb_stb_i   (stb3),
      .wb_we_i    (we3),
      .wb_adr_i   (adr3),
      .wb_dat_i   (wdat3),
      .wb_sel_i   (sel3),
      .wb_stall_o (stall3),
      .wb_ack_o   (ack3),
      .wb_err_o   (err3),
      .wb_dat_o   (rdat3)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] sel);
      logic [31:0] r;
      r = old;
      for (int n = 0; n < 4; n++) begin
         if (sel[n]) r[8*n +: 8] = d[8*n +: 8];
      end
      return r;
   endfunction

   // Region of dut0: [0x0000, 0x4000)
   function automatic sb_t mdl0(input logic we, input logic [31:0] adr, input logic [31:0] d,
                                input logic [3:0] sel);
      sb_t         e;
      logic [11:0] idx;
      idx    = adr[13:2];
      e.rd   = ~we;
      e.data = 32'h0;
`ifdef WB_RAM_SLAVE_ERR_EN
      e.err  = (adr >= 32'h0000_4000);
`else
      e.err  = 1'b0;
`endif
      if (!e.err) begin
         if (we) m0[idx] = merge(m0[idx], d, sel);
         else    e.data  = m0[idx];
      end
      return e;
   endfunction

   // Region of dut3: [0x10000, 0x10400)
   function automatic sb_t mdl3(input logic we, input logic [31:0] adr, input logic [31:0] d,
                                input logic [3:0] sel);
      sb_t         e;
      logic [31:0] off;
      logic [7:0]  idx;
      off    = adr - 32'h0001_0000;
      idx    = off[9:2];
      e.rd   = ~we;
      e.data = 32'h0;
`ifdef WB_RAM_SLAVE_ERR_EN
      e.err  = (adr < 32'h0001_0000) || (adr >= 32'h0001_0400);
`else
      e.err  = 1'b0;
`endif
      if (!e.err) begin
         if (we) m3[idx] = merge(m3[idx], d, sel);
         else    e.data  = m3[idx];
      end
      return e;
   endfunction

   always @(negedge clk) begin
      n_checks++;
      if ((ack0 === 1'b1 && err0 === 1'b1) || (ack0 !== 1'b1 && rdat0 !== 32'h0) || stall0 !== 1'b0) begin
         n_fail++;
         $display("FAIL b0_protocol: ack=%b err=%b stall=%b dat=%h, required one-hot resp, stall 0, dat 0 when idle",
                  ack0, err0, stall0, rdat0);
      end
      if (ack0 === 1'b1 || err0 === 1'b1) begin
         n_checks++;
         if (q0.size() == 0) begin
            n_fail++;
            $display("FAIL b0_unexpected: ack=%b err=%b, required no response", ack0, err0);
         end else begin
            e0 = q0.pop_front();
            if (err0 !== e0.err || (e0.rd && !e0.err && rdat0 !== e0.data)) begin
               n_fail++;
               $display("FAIL b0_resp: err=%b dat=%h, required err=%b dat=%h", err0, rdat0, e0.err, e0.data);
            end
         end
      end
   end

   always @(negedge clk) begin
      n_checks++;
      if ((ack3 === 1'b1 && err3 === 1'b1) || (ack3 !== 1'b1 && rdat3 !== 32'h0)) begin
         n_fail++;
         $display("FAIL b3_protocol: ack=%b err=%b dat=%h, required one-hot resp, dat 0 when idle",
                  ack3, err3, rdat3);
      end
      if (ack3 === 1'b1 || err3 === 1'b1) begin
         n_checks++;
         if (q3.size() == 0) begin
            n_fail++;
            $display("FAIL b3_unexpected: ack=%b err=%b, required no response", ack3, err3);
         end else begin
            e3 = q3.pop_front();
            if (err3 !== e3.err || (e3.rd && !e3.err && rdat3 !== e3.data)) begin
               n_fail++;
               $display("FAIL b3_resp: err=%b dat=%h, required err=%b dat=%h", err3, rdat3, e3.err, e3.data);
            end
         end
      end
   end

   task automatic b0_issue(input logic we, input logic [31:0] adr, input logic [31:0] d,
                           input logic [3:0] sel);
      @(posedge clk); #1;
      cyc0 = 1'b1; stb0 = 1'b1; we0 = we; adr0 = adr; wdat0 = d; sel0 = sel;
      q0.push_back(mdl0(we, adr, d, sel));
   endtask

   task automatic b0_idle();
      @(posedge clk); #1;
      stb0 = 1'b0;
   endtask

   task automatic b0_release();
      @(posedge clk); #1;
      cyc0 = 1'b0;
   endtask

   task automatic b3_issue(input logic we, input logic [31:0] adr, input logic [31:0] d,
                           input logic [3:0] sel, input bit expect_resp);
      @(posedge clk); #1;
      cyc3 = 1'b1; stb3 = 1'b1; we3 = we; adr3 = adr; wdat3 = d; sel3 = sel;
      if (expect_resp) q3.push_back(mdl3(we, adr, d, sel));
   endtask

   // Returns one time step after the accepting edge.
   task automatic b3_wait_accept();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 32 && !done; i++) begin
         @(negedge clk);
         if (stall3 === 1'b0) begin
            @(posedge clk); #1;
            done = 1'b1;
         end
      end
      if (!done) begin
         n_checks++; n_fail++;
         $display("FAIL b3_accept_timeout: stall=%b, required 0 within 32 cycles", stall3);
      end
   endtask

   task automatic b3_wait_resp();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 32 && !done; i++) begin
         @(negedge clk);
         if (ack3 === 1'b1 || err3 === 1'b1) done = 1'b1;
      end
      if (!done) begin
         n_checks++; n_fail++;
         $display("FAIL b3_resp_timeout: no ack/err, required response within 32 cycles");
      end
   endtask

   task automatic b3_single(input logic we, input logic [31:0] adr, input logic [31:0] d,
                            input logic [3:0] sel);
      b3_issue(we, adr, d, sel, 1'b1);
      b3_wait_accept();
      stb3 = 1'b0;
      b3_wait_resp();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({ack0, err0, stall0} !== 3'b000 || rdat0 !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_dut0: ack=%b err=%b stall=%b dat=%h, required all 0", ack0, err0, stall0, rdat0);
      end
      n_checks++;
      if ({ack3, err3, stall3} !== 3'b000 || rdat3 !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_dut3: ack=%b err=%b stall=%b dat=%h, required all 0", ack3, err3, stall3, rdat3);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_pipelined();
      b0_issue(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
      b0_issue(1'b0, 32'h10, 32'h0, 4'hF);
      @(negedge clk);
      n_checks++;
      if (ack0 !== 1'b1) begin
         n_fail++;
         $display("FAIL pipe_wr_ack: ack=%b, required 1", ack0);
      end
      b0_idle();
      @(negedge clk);
      n_checks++;
      if (ack0 !== 1'b1 || rdat0 !== 32'hDEAD_BEEF) begin
         n_fail++;
         $display("FAIL pipe_rd: ack=%b dat=%h, required 1 deadbeef", ack0, rdat0);
      end
      b0_release();
   endtask

   task automatic test_byte_lanes();
      b0_issue(1'b1, 32'h20, 32'h1122_3344, 4'hF);
      b0_issue(1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101);
      b0_issue(1'b0, 32'h20, 32'h0, 4'b0010);
      b0_idle();
      @(negedge clk);
      n_checks++;
      if (ack0 !== 1'b1 || rdat0 !== 32'h11BB_33DD) begin
         n_fail++;
         $display("FAIL byte_lanes: ack=%b dat=%h, required 1 11bb33dd", ack0, rdat0);
      end
      b0_release();
   endtask

   task automatic test_sel_zero();
      b0_issue(1'b1, 32'h30, 32'h5A5A_A5A5, 4'hF);
      b0_issue(1'b1, 32'h30, 32'hFFFF_FFFF, 4'h0);
      b0_issue(1'b0, 32'h30, 32'h0, 4'hF);
      b0_idle();
      @(negedge clk);
      n_checks++;
      if (ack0 !== 1'b1 || rdat0 !== 32'h5A5A_A5A5) begin
         n_fail++;
         $display("FAIL sel_zero: ack=%b dat=%h, required 1 5a5aa5a5", ack0, rdat0);
      end
      b0_release();
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 16; i++) b0_issue(1'b1, 32'h100 + 32'(4*i), $urandom, 4'hF);
      for (int i = 0; i < 32; i++) begin
         b0_issue(1'($urandom_range(0, 1)), 32'h100 + 32'(4*$urandom_range(0, 15)),
                  $urandom, 4'($urandom_range(0, 15)));
      end
      b0_idle();
      @(negedge clk);
      b0_release();
      n_checks++;
      if (q0.size() != 0) begin
         n_fail++;
         $display("FAIL b2b_drain: %0d responses outstanding, required 0", q0.size());
      end
   endtask

   task automatic test_range();
      b0_issue(1'b1, 32'h0, 32'h0BAD_F00D, 4'hF);
      b0_issue(1'b0, 32'h4000, 32'h0, 4'hF);
      b0_idle();
      @(negedge clk);
      n_checks++;
`ifdef WB_RAM_SLAVE_ERR_EN
      if (err0 !== 1'b1 || ack0 !== 1'b0 || rdat0 !== 32'h0) begin
         n_fail++;
         $display("FAIL range_rd: ack=%b err=%b dat=%h, required err only, dat 0", ack0, err0, rdat0);
      end
`else
      if (ack0 !== 1'b1 || err0 !== 1'b0 || rdat0 !== 32'h0BAD_F00D) begin
         n_fail++;
         $display("FAIL range_rd: ack=%b err=%b dat=%h, required ack, dat 0badf00d", ack0, err0, rdat0);
      end
`endif
      b0_release();
      b0_issue(1'b1, 32'h4, 32'h1234_5678, 4'hF);
      b0_issue(1'b1, 32'h4004, 32'h7777_0000, 4'hF);
      b0_issue(1'b0, 32'h4, 32'h0, 4'hF);
      b0_idle();
      @(negedge clk);
      b0_release();
   endtask

   task automatic test_wait_states();
      b3_single(1'b1, 32'h0001_0000, 32'hA0A0_0000, 4'hF);
      b3_single(1'b1, 32'h0001_0004, 32'hA0A0_0004, 4'hF);
      b3_single(1'b1, 32'h0001_0040, 32'hCAFE_F00D, 4'hF);
      b3_single(1'b1, 32'h0001_0044, 32'h4444_4444, 4'hF);
      b3_single(1'b1, 32'h0001_0080, 32'h8080_8080, 4'hF);
      b3_issue(1'b0, 32'h0001_0004, 32'h0, 4'hF, 1'b1);
      b3_wait_accept();
      adr3 = 32'h0001_0080;
      q3.push_back(mdl3(1'b0, 32'h0001_0080, 32'h0, 4'hF));
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         n_checks++;
         if (stall3 !== 1'b1 || ack3 !== (k == 4)) begin
            n_fail++;
            $display("FAIL wait_first T+%0d: stall=%b ack=%b, required stall 1 ack %0d", k, stall3, ack3, k == 4);
         end
      end
      @(negedge clk);
      n_checks++;
      if (stall3 !== 1'b0 || ack3 !== 1'b0) begin
         n_fail++;
         $display("FAIL wait_gap T+5: stall=%b ack=%b, required 0 0", stall3, ack3);
      end
      @(posedge clk); #1;
      stb3 = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         n_checks++;
         if (stall3 !== 1'b1 || ack3 !== (k == 4)) begin
            n_fail++;
            $display("FAIL wait_second +%0d: stall=%b ack=%b, required stall 1 ack %0d", k, stall3, ack3, k == 4);
         end
      end
   endtask

   task automatic test_err_wait();
      b3_issue(1'b0, 32'h0000_0000, 32'h0, 4'hF, 1'b1);
      b3_wait_accept();
      stb3 = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         n_checks++;
`ifdef WB_RAM_SLAVE_ERR_EN
         if (err3 !== (k == 4) || ack3 !== 1'b0) begin
            n_fail++;
            $display("FAIL err_latency +%0d: ack=%b err=%b, required ack 0 err %0d", k, ack3, err3, k == 4);
         end
`else
         if (ack3 !== (k == 4) || err3 !== 1'b0) begin
            n_fail++;
            $display("FAIL alias_latency +%0d: ack=%b err=%b, required ack %0d err 0", k, ack3, err3, k == 4);
         end
`endif
      end
      b3_single(1'b1, 32'h0000_0004, 32'h5555_AAAA, 4'hF);
      b3_single(1'b0, 32'h0001_0004, 32'h0, 4'hF);
   endtask

   task automatic test_cyc_drop();
      b3_issue(1'b0, 32'h0001_0040, 32'h0, 4'hF, 1'b0);
      b3_wait_accept();
      stb3 = 1'b0;
      @(posedge clk); #1;
      cyc3 = 1'b0;
      @(negedge clk);
      n_checks++;
      if (ack3 !== 1'b0 || err3 !== 1'b0) begin
         n_fail++;
         $display("FAIL drop_T+2: ack=%b err=%b, required 0 0", ack3, err3);
      end
      @(posedge clk); #1;
      cyc3 = 1'b1; stb3 = 1'b1; we3 = 1'b0; adr3 = 32'h0001_0044; sel3 = 4'hF;
      q3.push_back(mdl3(1'b0, 32'h0001_0044, 32'h0, 4'hF));
      @(negedge clk);
      n_checks++;
      if (stall3 !== 1'b0 || ack3 !== 1'b0 || err3 !== 1'b0) begin
         n_fail++;
         $display("FAIL drop_T+3: stall=%b ack=%b err=%b, required 0 0 0", stall3, ack3, err3);
      end
      @(posedge clk); #1;
      stb3 = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         n_checks++;
         if (ack3 !== (k == 4) || err3 !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_next +%0d: ack=%b err=%b, required ack %0d err 0", k, ack3, err3, k == 4);
         end
      end
   endtask

   task automatic test_reset_mid();
      b3_issue(1'b0, 32'h0001_0040, 32'h0, 4'hF, 1'b0);
      b3_wait_accept();
      stb3  = 1'b0;
      rst_n = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_checks++;
         if ({ack3, err3, stall3} !== 3'b000 || rdat3 !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid: ack=%b err=%b stall=%b dat=%h, required all 0", ack3, err3, stall3, rdat3);
         end
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         n_checks++;
         if (ack3 !== 1'b0 || err3 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_drop: ack=%b err=%b, required no response", ack3, err3);
         end
      end
      b3_single(1'b0, 32'h0001_0040, 32'h0, 4'hF);
      b0_issue(1'b0, 32'h10, 32'h0, 4'hF);
      b0_idle();
      @(negedge clk);
      n_checks++;
      if (ack0 !== 1'b1 || rdat0 !== 32'hDEAD_BEEF) begin
         n_fail++;
         $display("FAIL reset_keep: ack=%b dat=%h, required 1 deadbeef", ack0, rdat0);
      end
      b0_release();
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      cyc0 = 1'b0; stb0 = 1'b0; we0 = 1'b0; adr0 = 32'h0; wdat0 = 32'h0; sel0 = 4'h0;
      cyc3 = 1'b0; stb3 = 1'b0; we3 = 1'b0; adr3 = 32'h0; wdat3 = 32'h0; sel3 = 4'h0;
      for (int i = 0; i < 4096; i++) m0[i] = 32'h0;
      for (int i = 0; i < 256; i++)  m3[i] = 32'h0;

      test_reset();
      test_pipelined();
      test_byte_lanes();
      test_sel_zero();
      test_back_to_back();
      test_range();
      test_wait_states();
      test_err_wait();
      test_cyc_drop();
      test_reset_mid();

      repeat (3) @(negedge clk);
      n_checks++;
      if (q0.size() != 0 || q3.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d/%0d responses outstanding, required 0/0", q0.size(), q3.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
